// File: rtl/aes_spi_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_spi_bridge_if
// Description : SPI host pins and AES core handshake bundle for aes_spi_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_spi_bridge_if;
   logic         spi_sclk_i;
   logic         spi_cs_n_i;
   logic         spi_mosi_i;
   logic         spi_miso_o;
   logic         aes_load_o;
   logic         aes_dec_o;
   logic [127:0] aes_data_o;
   logic         aes_busy_i;
   logic [127:0] aes_result_i;
   logic         done_o;

   // The bridge is the slave; the master side is the SPI host plus AES core.
   modport slave (
      input  spi_sclk_i, spi_cs_n_i, spi_mosi_i, aes_busy_i, aes_result_i,
      output spi_miso_o, aes_load_o, aes_dec_o, aes_data_o, done_o
   );

   modport master (
      output spi_sclk_i, spi_cs_n_i, spi_mosi_i, aes_busy_i, aes_result_i,
      input  spi_miso_o, aes_load_o, aes_dec_o, aes_data_o, done_o
   );
endinterface
`default_nettype wire

// File: rtl/aes_spi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_spi_bridge
// Description : SPI mode-0 slave that loads a 128-bit AES core and returns
//               its result or a status byte over MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_spi_bridge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   aes_spi_bridge_if.slave bus
);

   localparam logic [7:0] c_cmd_enc    = 8'h01;
   localparam logic [7:0] c_cmd_dec    = 8'h02;
   localparam logic [7:0] c_cmd_read   = 8'h03;
   localparam logic [7:0] c_cmd_status = 8'h04;
   localparam logic [7:0] c_cmd_bits   = 8'd8;
   localparam logic [7:0] c_last_bit   = 8'd136;
   localparam logic [1:0] c_arm_limit  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // SPI pin synchronisers
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_i};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   logic w_sclk;
   logic w_cs_n;
   logic w_mosi;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_fall;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_prev & ~w_cs_n;
   assign w_sclk_fall = ~w_sclk & r_sclk_prev & ~w_cs_n;
   assign w_cs_fall   = ~w_cs_n & r_cs_prev;

   // ------------------------------------------------------------------------
   // Frame decoder, load control and capture FSM
   // ------------------------------------------------------------------------
   logic [7:0]   r_bit_cnt;
   logic [127:0] r_rx_shift;
   logic [127:0] r_tx_shift;
   logic         r_tx_active;
   logic         r_is_block;
   logic         r_is_dec;
   logic [127:0] r_data;
   logic         r_dec;
   logic         r_load;
   logic         r_done;
   logic [127:0] r_result;
   logic         r_result_valid;
   logic         r_pending;
   logic         r_err;
   state_t       r_state;
   logic [1:0]   r_arm_cnt;

   logic [7:0]   w_cnt_next;
   logic [127:0] w_rx_next;

   assign w_cnt_next = r_bit_cnt + 8'd1;
   assign w_rx_next  = {r_rx_shift[126:0], w_mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt      <= '0;
         r_rx_shift     <= '0;
         r_tx_shift     <= '0;
         r_tx_active    <= 1'b0;
         r_is_block     <= 1'b0;
         r_is_dec       <= 1'b0;
         r_data         <= '0;
         r_dec          <= 1'b0;
         r_load         <= 1'b0;
         r_done         <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_pending      <= 1'b0;
         r_err          <= 1'b0;
         r_state        <= ST_IDLE;
         r_arm_cnt      <= '0;
      end else begin
         r_load <= 1'b0;
         r_done <= 1'b0;

         if (w_cs_n) begin
            // Deselect drops any partial frame; a half-received block never loads.
            r_bit_cnt   <= '0;
            r_tx_active <= 1'b0;
            r_is_block  <= 1'b0;
         end else if (w_cs_fall) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_active <= 1'b0;
            r_is_block  <= 1'b0;
         end else if (w_sclk_rise && (r_bit_cnt != c_last_bit)) begin
            r_bit_cnt  <= w_cnt_next;
            r_rx_shift <= w_rx_next;
            if (w_cnt_next == c_cmd_bits) begin
               case (w_rx_next[7:0])
                  c_cmd_enc: begin
                     r_is_block <= 1'b1;
                     r_is_dec   <= 1'b0;
                  end
                  c_cmd_dec: begin
                     r_is_block <= 1'b1;
                     r_is_dec   <= 1'b1;
                  end
                  c_cmd_read: begin
                     r_tx_shift  <= r_result;
                     r_tx_active <= 1'b1;
                  end
                  c_cmd_status: begin
                     r_tx_shift  <= {5'b0, r_err, r_result_valid, r_pending, 120'b0};
                     r_tx_active <= 1'b1;
                     r_err       <= 1'b0;
                  end
                  default: r_err <= 1'b1;
               endcase
            end else if ((w_cnt_next == c_last_bit) && r_is_block) begin
               if (r_pending || bus.aes_busy_i) begin
                  r_err <= 1'b1;
               end else begin
                  r_data         <= w_rx_next;
                  r_dec          <= r_is_dec;
                  r_load         <= 1'b1;
                  r_pending      <= 1'b1;
                  r_result_valid <= 1'b0;
               end
            end
         end else if (w_sclk_fall && r_tx_active && (r_bit_cnt > c_cmd_bits)) begin
            // The fall right after the command byte keeps bit 127 for the first data rise.
            r_tx_shift <= {r_tx_shift[126:0], 1'b0};
         end

         case (r_state)
            ST_IDLE: begin
               if (r_load) begin
                  r_state   <= ST_ARMED;
                  r_arm_cnt <= '0;
               end
            end
            ST_ARMED: begin
               if (bus.aes_busy_i) begin
                  r_state <= ST_RUN;
               end else if (r_arm_cnt == c_arm_limit) begin
                  r_state   <= ST_IDLE;
                  r_err     <= 1'b1;
                  r_pending <= 1'b0;
               end else begin
                  r_arm_cnt <= r_arm_cnt + 2'd1;
               end
            end
            ST_RUN: begin
               if (!bus.aes_busy_i) begin
                  r_state        <= ST_IDLE;
                  r_result       <= bus.aes_result_i;
                  r_result_valid <= 1'b1;
                  r_pending      <= 1'b0;
                  r_done         <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.spi_miso_o = r_tx_active & r_tx_shift[127];
   assign bus.aes_load_o = r_load;
   assign bus.aes_dec_o  = r_dec;
   assign bus.aes_data_o = r_data;
   assign bus.done_o     = r_done;

endmodule
`default_nettype wire

// File: doc/aes_spi_bridge.md
Name: aes_spi_bridge

Overview:
- SPI mode-0 slave front end for the static-key 128-bit AES core in the spi_aes_scan example.
- Receives a command byte plus an optional 128-bit block from an external host. Drives the core's load/dec/data inputs, watches its busy output, and captures the result.
- Returns the result or a status byte to the host over MISO.
- Sits directly upstream of the AES core and also consumes its output.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on spi_sclk_i, spi_cs_n_i and spi_mosi_i. Minimum 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_sclk_i  in  1  SPI clock, asynchronous to clk; frequency ≤ clk/8.
- spi_cs_n_i  in  1  SPI chip select, active low.
- spi_mosi_i  in  1  host-to-bridge data, MSB first.
- spi_miso_o  out  1  bridge-to-host data, MSB first.
- aes_load_o  out  1  one-cycle start pulse to the core.
- aes_dec_o  out  1  0 = encrypt, 1 = decrypt; registered, valid with load.
- aes_data_o  out  128  block to the core; registered, held until the next load.
- aes_busy_i  in  1  core busy flag.
- aes_result_i  in  128  core output block.
- done_o  out  1  one-cycle pulse when a result is captured.

Behaviour:
- Reset: all outputs 0; result_reg = 0; flags result_valid, pending and err = 0; FSM = IDLE.
- Synchronisation and edges:
  - sclk, cs_n and mosi pass through SYNC_STAGES flip-flops.
  - sclk rise/fall are detected from the synchronised value and the previous sample.
  - Sampling happens only while synchronised cs_n = 0.
- Frame:
  - Synchronised cs_n falling resets the bit counter (8 bits wide, saturates at 136) and clears the shift registers.
  - Each sclk rise shifts mosi into rx_shift.
  - Bits 1–8 form the command; bits 9–136 form the data block.
  - Bits beyond 136 are ignored.
- Commands, decoded on the 8th rise:
  - 0x01 ENC: receive 128 bits. On the 136th rise, aes_data_o <= rx block, aes_dec_o <= 0, and aes_load_o is pulsed the next clk.
  - 0x02 DEC: same as ENC, with aes_dec_o <= 1.
  - 0x03 READ: on the 8th rise, tx_shift <= result_reg (snapshot).
  - 0x04 STATUS: on the 8th rise, tx_shift[127:120] <= {5'b0, err, result_valid, pending}. err clears at the same time.
  - Any other value: set err; ignore the rest of the frame; MISO = 0.
- MISO timing:
  - spi_miso_o = tx_shift[127] while a READ or STATUS frame is in its data phase; 0 otherwise.
  - tx_shift shifts left on each sclk fall after the 8th rise.
- Load rules:
  - ENC/DEC completed while pending = 1 or aes_busy_i = 1 is rejected: no load, err set.
  - A load sets pending = 1 and clears result_valid.
- Capture FSM, states IDLE → ARMED → RUN → IDLE:
  - IDLE → ARMED: on the load pulse.
  - ARMED → RUN: when aes_busy_i = 1.
  - RUN → IDLE: on the first cycle with aes_busy_i = 0. In that cycle result_reg <= aes_result_i, result_valid = 1, pending = 0, and done_o pulses.
  - ARMED with aes_busy_i = 0 for 4 consecutive cycles → IDLE: err set, pending cleared, no capture.
- Boundary conditions:
  - CS rises mid-frame: partial data discarded, no load, counters reset; the capture FSM is unaffected.
  - Capture during a READ frame: the tx snapshot is unchanged; the new result appears on the next READ.
  - Reset asserted mid-operation: everything returns to reset values immediately; a running core is ignored.
  - SPI activity while a load is pending is allowed, so STATUS can be polled.

Test Plan:
- Reset: with rst high, all outputs are 0; after release, a STATUS frame (0x04) returns 0x00.
- ENC frame 0x01 + 00112233445566778899aabbccddeeff, with the core's KEY = 2b7e151628aed2a6abf7976676151301:
  - exactly one aes_load_o pulse, aes_dec_o = 0;
  - then done_o pulses;
  - READ (0x03) returns bb543294c636da27e6701c7e66814a19.
- DEC frame 0x02 + bb543294c636da27e6701c7e66814a19: aes_dec_o = 1; READ returns 00112233445566778899aabbccddeeff.
- Polling and overrun: STATUS during computation returns 0x01. A second ENC sent while pending gives no load, and the next STATUS returns 0x05 (err + pending). The STATUS after that returns 0x02 or 0x01 depending on completion.
- Abort: CS raised after 70 data bits of an ENC frame → no load; aes_data_o keeps its previous value; STATUS returns 0x02 when result_valid was previously 1.
- Bad command 0x7F followed by 128 clocks: MISO stays 0, no load, next STATUS returns 0x04 then 0x00.
